// File: rtl/sysmem_pkg.sv
// sysmem_pkg: shared FSM state type, lane width and address-window decode for the byte-lane system RAM
package sysmem_pkg;
  typedef enum logic [1:0] {IDLE, PIPE, RESP} sysmem_state_t;
  localparam int SYSMEM_LANE_W = 8;
  function automatic logic sysmem_hit(input logic [31:0] addr, input logic [31:0] base, input int addr_w);
    return (addr >> (addr_w + 2)) == (base >> (addr_w + 2));
  endfunction
endpackage

// File: rtl/sysmem_lane.sv
// sysmem_lane: one 8-bit single-port block RAM lane, synchronous write-first read with registered output
module sysmem_lane import sysmem_pkg::*; #(
  parameter int ADDR_W = 10
) (
  input  logic                     clka,
  input  logic [ADDR_W-1:0]        addra,
  input  logic                     cea,
  input  logic                     wea,
  input  logic [SYSMEM_LANE_W-1:0] dia,
  output logic [SYSMEM_LANE_W-1:0] doa
);
  logic [SYSMEM_LANE_W-1:0] ram [2**ADDR_W];
  // enabled access: optional write, output register loads the addressed word
  always_ff @(posedge clka)
    if (cea) begin
      if (wea) ram[addra] <= dia;
      doa <= wea ? dia : ram[addra];
    end
endmodule

// File: rtl/sysmem_bytelane.sv
// sysmem_bytelane: LANES byte-lane RAM behind a valid/ready port with window decode; SYSMEM_OUTREG_EN adds an output register stage
module sysmem_bytelane import sysmem_pkg::*; #(
  parameter int          LANES     = 4,
  parameter int          ADDR_W    = 10,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic                           clka,
  input  logic                           rsta,
  input  logic                           mem_valid,
  input  logic [31:0]                    mem_addr,
  input  logic [SYSMEM_LANE_W*LANES-1:0] mem_wdata,
  input  logic [LANES-1:0]               mem_wstrb,
  output logic                           mem_ready,
  output logic [SYSMEM_LANE_W*LANES-1:0] mem_rdata,
  output logic                           mem_err
);
  localparam int DW = SYSMEM_LANE_W * LANES;
  sysmem_state_t     state;
  logic              hit, accept, rd_q, err_q;
  logic [ADDR_W-1:0] idx;
  logic [LANES-1:0]  cea, wea;
  logic [DW-1:0]     ram_do, hold_q, resp_data;
  assign idx    = mem_addr[ADDR_W+1:2];
  assign hit    = sysmem_hit(mem_addr, BASE_ADDR, ADDR_W);
  assign accept = state == IDLE && mem_valid && hit && !rsta;
  assign wea    = accept ? mem_wstrb : '0;
  assign cea    = accept ? (mem_wstrb == '0 ? '1 : mem_wstrb) : '0;
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    sysmem_lane #(.ADDR_W(ADDR_W)) u_lane (
      .clka  (clka),
      .addra (idx),
      .cea   (cea[i]),
      .wea   (wea[i]),
      .dia   (mem_wdata[SYSMEM_LANE_W*i +: SYSMEM_LANE_W]),
      .doa   (ram_do[SYSMEM_LANE_W*i +: SYSMEM_LANE_W])
    );
  end
`ifdef SYSMEM_OUTREG_EN
  localparam sysmem_state_t AFTER_IDLE = PIPE;
  logic [DW-1:0] pipe_q;
  // output stage captures the RAM word (or zero for write/miss) one cycle after the access
  always_ff @(posedge clka)
    if (rsta) pipe_q <= '0;
    else if (state == PIPE) pipe_q <= rd_q ? ram_do : '0;
  assign resp_data = pipe_q;
`else
  localparam sysmem_state_t AFTER_IDLE = RESP;
  assign resp_data = rd_q ? ram_do : '0;
`endif
  // request FSM: accept in IDLE, respond for one cycle in RESP, remember the response for the hold value
  always_ff @(posedge clka)
    if (rsta) begin
      state  <= IDLE;
      rd_q   <= 1'b0;
      err_q  <= 1'b0;
      hold_q <= '0;
    end else
      case (state)
        IDLE: if (mem_valid) begin
          state <= AFTER_IDLE;
          rd_q  <= hit && mem_wstrb == '0;
          err_q <= !hit;
        end
        PIPE: state <= RESP;
        RESP: begin
          state  <= IDLE;
          hold_q <= resp_data;
        end
        default: state <= IDLE;
      endcase
  assign mem_ready = state == RESP;
  assign mem_err   = mem_ready && err_q;
  assign mem_rdata = mem_ready ? resp_data : hold_q;
endmodule

// File: tb/tb_sysmem_bytelane.sv
// tb_sysmem_bytelane: scoreboard bench for sysmem_bytelane, latency follows SYSMEM_OUTREG_EN
module tb_sysmem_bytelane;
`ifdef SYSMEM_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  logic        clka = 1'b0, rsta = 1'b1, mem_valid = 1'b0;
  logic [31:0] mem_addr = '0, mem_wdata = '0;
  logic [3:0]  mem_wstrb = '0;
  logic        mem_ready, mem_err;
  logic [31:0] mem_rdata;
  int          errors = 0, checks = 0;
  logic [32:0] sb[$];
  logic [31:0] last_rdata = '0;
  logic [31:0] model [8];
  sysmem_bytelane #(.LANES(4), .ADDR_W(10), .BASE_ADDR(32'h0)) dut (
    .clka(clka), .rsta(rsta), .mem_valid(mem_valid), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata), .mem_err(mem_err)
  );
  always #5 clka = ~clka;
  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask
  task automatic start_req(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb,
                           input logic [31:0] exp_rdata, input logic exp_err);
    @(negedge clka);
    check("idle_ready", mem_ready, 0);
    check("idle_err", mem_err, 0);
    check("idle_hold", mem_rdata, last_rdata);
    mem_addr  = addr;
    mem_wdata = wdata;
    mem_wstrb = wstrb;
    mem_valid = 1'b1;
    sb.push_back({exp_err, exp_rdata});
  endtask
  task automatic wait_resp(input string tag);
    int n;
    logic [32:0] e;
    n = 0;
    do begin
      @(negedge clka);
      n++;
    end while (!mem_ready && n < 8);
    e = sb.pop_front();
    if (!mem_ready) check({tag, "_timeout"}, 0, 1);
    else begin
      check({tag, "_rdata"}, mem_rdata, e[31:0]);
      check({tag, "_err"}, mem_err, e[32]);
      check({tag, "_lat"}, n, LAT);
      last_rdata = e[31:0];
    end
    mem_valid = 1'b0;
    mem_wstrb = '0;
  endtask
  task automatic req(input string tag, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] wstrb, input logic [31:0] exp_rdata, input logic exp_err);
    start_req(addr, wdata, wstrb, exp_rdata, exp_err);
    wait_resp(tag);
  endtask
  initial begin
    repeat (2) @(negedge clka);
    start_req(32'h0000_1000, '0, '0, '0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clka);
      check("rst_ready", mem_ready, 0);
      check("rst_err", mem_err, 0);
      check("rst_rdata", mem_rdata, 0);
    end
    rsta = 1'b0;
    wait_resp("first_after_rst");
    req("wr_full", 32'h10, 32'hDEADBEEF, 4'hF, '0, 1'b0);
    req("rd_full", 32'h10, '0, 4'h0, 32'hDEADBEEF, 1'b0);
    req("pre_20", 32'h20, 32'h11223344, 4'hF, '0, 1'b0);
    req("wr_strb", 32'h20, 32'hAABBCCDD, 4'b0101, '0, 1'b0);
    req("rd_strb", 32'h20, '0, 4'h0, 32'h11BB33DD, 1'b0);
    req("pre_0", 32'h0, 32'hCAFEF00D, 4'hF, '0, 1'b0);
    req("miss_rd", 32'h0000_1000, '0, 4'h0, '0, 1'b1);
    req("miss_wr", 32'h0000_1000, 32'hFFFFFFFF, 4'hF, '0, 1'b1);
    req("rd_0_after_miss", 32'h0, '0, 4'h0, 32'hCAFEF00D, 1'b0);
    req("wr_top", 32'hFFC, 32'h0000_00A5, 4'hF, '0, 1'b0);
    req("rd_0_wrap", 32'h0, '0, 4'h0, 32'hCAFEF00D, 1'b0);
    req("rd_top", 32'hFFC, '0, 4'h0, 32'h0000_00A5, 1'b0);
    req("pre_40", 32'h40, 32'h0BADF00D, 4'hF, '0, 1'b0);
    @(negedge clka);
    mem_addr  = 32'h40;
    mem_wdata = 32'h12345678;
    mem_wstrb = 4'hF;
    mem_valid = 1'b1;
    rsta      = 1'b1;
    @(negedge clka);
    rsta      = 1'b0;
    mem_valid = 1'b0;
    mem_wstrb = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clka);
      check("midrst_ready", mem_ready, 0);
    end
    last_rdata = '0;
    req("rd_40_after_rst", 32'h40, '0, 4'h0, 32'h0BADF00D, 1'b0);
    for (int i = 0; i < 8; i++) begin
      model[i] = $urandom;
      req("rnd_wr", 32'h100 + 4 * i, model[i], 4'hF, '0, 1'b0);
    end
    for (int i = 0; i < 8; i++) begin
      logic [31:0] d;
      logic [3:0]  s;
      d = $urandom;
      s = 4'($urandom_range(0, 15));
      if (s == 4'h0) s = 4'h9;
      for (int b = 0; b < 4; b++) if (s[b]) model[i][8*b +: 8] = d[8*b +: 8];
      req("rnd_strb", 32'h100 + 4 * i, d, s, '0, 1'b0);
    end
    for (int i = 0; i < 8; i++) req("rnd_rd", 32'h100 + 4 * i, '0, 4'h0, model[i], 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
